code_conv_sequencer: RTL
========================

Name: code_conv_sequencer

Overview:
- Multi-digit BCD code-conversion controller for the universal code converter.
- Accepts a packed NDIG-digit BCD word and a conversion mode over a valid/ready handshake.
- Streams the digits one per cycle, LSB digit first, through a single shared combinational digit converter.
- Reassembles the converted word and returns it with error status over a second valid/ready handshake.

Parameters:
- NDIG, 4, number of BCD digits per word; data width is 4*NDIG.
- ABORT_ON_ERR, 0. If 1, conversion stops at the first invalid digit. If 0, all digits are converted.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_bcd  in  4*NDIG  packed BCD digits; digit k = bits [4k+3:4k].
- in_mode  in  2  00 = excess-3, 01 = BCD-to-Gray, 10 = 8421-to-2421, 11 = reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_code  out  4*NDIG  converted word.
- out_err  out  1  at least one invalid digit (>9), or reserved mode.
- out_err_idx  out  clog2(NDIG) (min 1)  index of the first invalid digit; 0 if none.
- busy  out  1  high in CONV or DONE.

Behaviour:
- Reset values (rst_n sampled low at a rising edge): state = IDLE, in_ready = 1, out_valid = 0, out_code = 0, out_err = 0, out_err_idx = 0, busy = 0, digit index = 0.
- Reset mid-operation discards all work in progress; there is no partial output.
- FSM states:
  - IDLE: on in_valid & in_ready, latch in_bcd and in_mode, clear the result and error registers, set idx = 0.
    - If the mode is valid, go to CONV.
    - If in_mode = 11, go directly to DONE with out_code = 0, out_err = 1, out_err_idx = 0.
  - CONV: each cycle, convert latched digit idx and write the result into nibble idx of out_code.
    - If the digit is >9: write 4'hF, set out_err. out_err_idx is captured only on the first error.
    - If idx = NDIG-1, or (ABORT_ON_ERR = 1 and the current digit is invalid), go to DONE. Otherwise idx++.
    - On abort, the unconverted nibbles remain 0.
  - DONE: out_valid = 1, and out_code, out_err and out_err_idx are held stable. On out_ready, go to IDLE and clear out_valid the same edge.
- Latency: out_valid rises NDIG cycles after the accepting edge (4 for the default). There is no back-to-back acceptance; at least one IDLE cycle separates requests.
- Backpressure: out_ready may stay low indefinitely, and the outputs do not change. in_valid is ignored outside IDLE.
- Digit conversions (d is a 4-bit value, valid range 0..9):
  - excess-3: d + 3.
  - Gray: d ^ (d >> 1).
  - 2421: d if d ≤ 4, else d + 6.
- Simultaneous events: out_ready arriving in the same cycle DONE is first entered is honoured, so DONE lasts one cycle.

Decomposition:
- Shared package/header holds:
  - mode encodings MODE_EX3, MODE_GRAY, MODE_2421, MODE_RSVD;
  - state encodings ST_IDLE, ST_CONV, ST_DONE;
  - constant BAD_NIBBLE = 4'hF.
- Sub-module digit_conv: combinational; inputs digit[3:0] and mode[1:0]; outputs code[3:0] and err. One instance only, time-shared by the sequencer.

Test Plan:
- Reset, then in_bcd = 16'h1234, mode = 00 → out_code = 16'h4567, out_err = 0, out_valid exactly 4 cycles after acceptance.
- in_bcd = 16'h1234, mode = 01 → out_code = 16'h1326; mode = 10 → 16'h1234; in_bcd = 16'h0987, mode = 10 → 16'h0FED.
- in_bcd = 16'h12A4, mode = 00, ABORT_ON_ERR = 0 → out_code = 16'h45F7, out_err = 1, out_err_idx = 1.
  - With ABORT_ON_ERR = 1 → out_code = 16'h00F7, out_err_idx = 1, out_valid 2 cycles after acceptance.
- mode = 11 → out_valid on the next cycle, out_code = 0, out_err = 1. Hold out_ready = 0 for 10 cycles → outputs stable, in_ready = 0, and a new in_valid is ignored.
- Drive rst_n low for one cycle at CONV idx = 2 → next cycle IDLE, out_valid = 0, in_ready = 1. A following request 16'h9999, mode = 00 → 16'hCCCC, out_err = 0.

Source files
------------

// File: rtl/code_conv_sequencer_pkg.sv
// Shared encodings for the multi-digit BCD code-conversion sequencer.
// Mode, state and error-nibble constants used by sequencer and digit converter.
package code_conv_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_EX3  = 2'b00,
        MODE_GRAY = 2'b01,
        MODE_2421 = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CONV = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [3:0] BAD_NIBBLE = 4'hF;

endpackage

// File: rtl/code_conv_sequencer_digit_conv.sv
// Combinational single-digit converter, time-shared by the sequencer.
// Invalid digits and the reserved mode both yield BAD_NIBBLE with err set.
module digit_conv
    import code_conv_sequencer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [1:0] mode,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = BAD_NIBBLE;
        err  = 1'b1;
        if (digit <= 4'd9) begin
            err = 1'b0;
            case (mode)
                MODE_EX3:  code = digit + 4'd3;
                MODE_GRAY: code = digit ^ (digit >> 1);
                MODE_2421: code = (digit <= 4'd4) ? digit : digit + 4'd6;
                default: begin
                    code = BAD_NIBBLE;
                    err  = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/code_conv_sequencer.sv
// Multi-digit BCD converter: accepts a word, streams digits LSB first
// through one digit_conv, and returns the reassembled word with error status.
module code_conv_sequencer
    import code_conv_sequencer_pkg::*;
#(
    parameter int NDIG = 4,
    parameter bit ABORT_ON_ERR = 1'b0,
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1,
    localparam int W = 4 * NDIG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_bcd,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_code,
    output logic          out_err,
    output logic [IW-1:0] out_err_idx,
    output logic          busy
);

    state_e        state_q;
    state_e        state_d;
    logic [W-1:0]  bcd_q;
    logic [1:0]    mode_q;
    logic [W-1:0]  res_q;
    logic          err_q;
    logic [IW-1:0] eidx_q;
    logic [IW-1:0] idx_q;

    logic [3:0] dig;
    logic [3:0] dig_code;
    logic       dig_err;
    logic       accept;
    logic       last;

    assign dig    = bcd_q[{idx_q, 2'b00} +: 4];
    assign accept = in_valid && (state_q == ST_IDLE);
    assign last   = (idx_q == IW'(NDIG - 1));

    digit_conv u_conv (
        .digit (dig),
        .mode  (mode_q),
        .code  (dig_code),
        .err   (dig_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = (in_mode == MODE_RSVD) ? ST_DONE : ST_CONV;
            end
            ST_CONV: begin
                if (last || (ABORT_ON_ERR && dig_err))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Result and error registers double as the output holding registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            mode_q <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            eidx_q <= '0;
            idx_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        bcd_q  <= in_bcd;
                        mode_q <= in_mode;
                        res_q  <= '0;
                        err_q  <= (in_mode == MODE_RSVD);
                        eidx_q <= '0;
                        idx_q  <= '0;
                    end
                end
                ST_CONV: begin
                    res_q[{idx_q, 2'b00} +: 4] <= dig_code;
                    if (dig_err) begin
                        err_q <= 1'b1;
                        if (!err_q)
                            eidx_q <= idx_q;
                    end
                    if (!last)
                        idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign busy        = (state_q == ST_CONV) || (state_q == ST_DONE);
    assign out_code    = res_q;
    assign out_err     = err_q;
    assign out_err_idx = eidx_q;

endmodule
